// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, controller states and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1001
  } alu_op_t;

  localparam logic [3:0] ALU_OP_LAST = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } ctrl_state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Single-cycle 32-bit ALU with Z/N/C/V flags; C is carry for ADD and no-borrow for SUB.
module alu_share_ctrl_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] input_A,
  input  logic [DATA_W-1:0] input_B,
  input  logic [3:0]        ALU_Control,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              negative,
  output logic              carry,
  output logic              overflow
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;
  logic [4:0]      shamt;

  assign sum_ext  = {1'b0, input_A} + {1'b0, input_B};
  assign diff_ext = {1'b0, input_A} - {1'b0, input_B};
  assign shamt    = input_B[4:0];

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (ALU_Control)
      OP_ADD: begin
        result   = sum_ext[DATA_W-1:0];
        carry    = sum_ext[DATA_W];
        overflow = (input_A[DATA_W-1] == input_B[DATA_W-1]) &&
                   (sum_ext[DATA_W-1] != input_A[DATA_W-1]);
      end
      OP_SUB: begin
        result   = diff_ext[DATA_W-1:0];
        // A borrow shows up as the extended top bit; C reports its absence
        carry    = ~diff_ext[DATA_W];
        overflow = (input_A[DATA_W-1] != input_B[DATA_W-1]) &&
                   (diff_ext[DATA_W-1] != input_A[DATA_W-1]);
      end
      OP_AND:  result = input_A & input_B;
      OP_OR:   result = input_A | input_B;
      OP_XOR:  result = input_A ^ input_B;
      OP_SLL:  result = input_A << shamt;
      OP_SRL:  result = input_A >> shamt;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(input_A) < $signed(input_B)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, input_A < input_B};
      OP_SRA:  result = $unsigned($signed(input_A) >>> shamt);
      default: result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[DATA_W-1];

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one ALU between two requesters, with a
// registered, tagged response held under backpressure.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  ctrl_state_t       state, state_next;
  logic              last_id;
  logic              grant_any, grant_id;
  logic [DATA_W-1:0] op_a, op_b;
  logic [3:0]        op_code;
  logic              op_id;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              illegal;

  alu_share_ctrl_alu #(.DATA_W(DATA_W)) u_alu (
    .input_A     (op_a),
    .input_B     (op_b),
    .ALU_Control (op_code),
    .result      (alu_result),
    .zero        (alu_flags[FLAG_Z]),
    .negative    (alu_flags[FLAG_N]),
    .carry       (alu_flags[FLAG_C]),
    .overflow    (alu_flags[FLAG_V])
  );

  assign illegal = (op_code > ALU_OP_LAST);

  // On a tie, the requester that did not win last time gets the grant
  always_comb begin
    state_next = state;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          grant_any  = req0_valid | req1_valid;
          grant_id   = (req0_valid && req1_valid) ? ~last_id : req1_valid;
          req0_ready = grant_any && !grant_id;
          req1_ready = grant_any && grant_id;
          if (grant_any) state_next = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_id    <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      op_id      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      txn_count  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_any) begin
        op_a    <= grant_id ? req1_a  : req0_a;
        op_b    <= grant_id ? req1_b  : req0_b;
        op_code <= grant_id ? req1_op : req0_op;
        op_id   <= grant_id;
        last_id <= grant_id;
      end
      if (state == EXEC) begin
        rsp_id     <= op_id;
        rsp_result <= illegal ? '0 : alu_result;
        rsp_flags  <= illegal ? 4'b0000 : alu_flags;
        rsp_err    <= illegal;
      end
      if (state == RESP && rsp_ready) txn_count <= txn_count + CNT_W'(1);
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a default instance plus a CNT_W=2 twin for counter wrap.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [15:0] txn_count;

  logic        w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id, w_rsp_err, w_busy;
  logic [31:0] w_rsp_result;
  logic [3:0]  w_rsp_flags;
  logic [1:0]  w_txn_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy), .txn_count(txn_count)
  );

  alu_share_ctrl #(.DATA_W(32), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id), .rsp_result(w_rsp_result),
    .rsp_flags(w_rsp_flags), .rsp_err(w_rsp_err), .busy(w_busy), .txn_count(w_txn_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one request at the next negedge and return just after its handshake edge
  task automatic applyStimulus(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("grant_timeout", {31'b0, n < 20}, 32'd1);
    checkOutput("w_grant", {31'b0, id ? w_req1_ready : w_req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Full transaction with rsp_ready held high; ends at the negedge inside RESP
  task automatic runOp(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [3:0] exp_flags, input logic exp_err);
    applyStimulus(id, op, a, b);
    @(negedge clk);
    checkOutput("exec_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("exec_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("resp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("resp_id", {31'b0, rsp_id}, {31'b0, id});
    checkOutput("resp_result", rsp_result, exp_res);
    checkOutput("resp_flags", {28'b0, rsp_flags}, {28'b0, exp_flags});
    checkOutput("resp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    checkOutput("w_resp_valid", {31'b0, w_rsp_valid}, 32'd1);
    checkOutput("w_resp_id", {31'b0, w_rsp_id}, {31'b0, id});
    checkOutput("w_resp_result", w_rsp_result, exp_res);
    checkOutput("w_resp_flags", {28'b0, w_rsp_flags}, {28'b0, exp_flags});
    checkOutput("w_resp_err", {31'b0, w_rsp_err}, {31'b0, exp_err});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit exp_id;
    int n, r0, r1;

    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = OP_ADD;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_ADD;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready0", {31'b0, req0_ready}, 32'd0);
    checkOutput("rst_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_w_busy", {31'b0, w_busy}, 32'd0);
    checkOutput("rst_id", {31'b0, rsp_id}, 32'd0);
    checkOutput("rst_result", rsp_result, 32'd0);
    checkOutput("rst_flags", {28'b0, rsp_flags}, 32'd0);
    checkOutput("rst_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_count", {16'b0, txn_count}, 32'd0);
    reset = 1'b0;
    req0_valid = 1'b0;

    $display("[TB] add with overflow");
    runOp(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 1'b0);

    $display("[TB] tie and alternation");
    doReset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1;    req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hF0;   req1_b = 32'hFF;
    #1;
    exp_id = 1'b0; r0 = 0; r1 = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      checkOutput("tie_timeout", {31'b0, n < 20}, 32'd1);
      checkOutput("tie_ready0", {31'b0, req0_ready}, {31'b0, !exp_id});
      checkOutput("tie_ready1", {31'b0, req1_ready}, {31'b0, exp_id});
      r0 += int'(req0_ready); r1 += int'(req1_ready);
      @(posedge clk);
      @(negedge clk);
      r0 += int'(req0_ready); r1 += int'(req1_ready);
      @(negedge clk);
      r0 += int'(req0_ready); r1 += int'(req1_ready);
      checkOutput("tie_rsp_id", {31'b0, rsp_id}, {31'b0, exp_id});
      checkOutput("tie_result", rsp_result, exp_id ? 32'h0000_000F : 32'h0000_0003);
      exp_id = ~exp_id;
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checkOutput("tie_count", {16'b0, txn_count}, 32'd4);
    checkOutput("tie_pulses0", r0, 32'd2);
    checkOutput("tie_pulses1", r1, 32'd2);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, OP_SUB, 32'd5, 32'd5);
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd10; req0_b = 32'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_result", rsp_result, 32'd0);
      checkOutput("bp_flags", {28'b0, rsp_flags}, 32'b1010);
      checkOutput("bp_id", {31'b0, rsp_id}, 32'd1);
      checkOutput("bp_no_ready", {31'b0, req0_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("bp_rel_busy", {31'b0, busy}, 32'd0);
    checkOutput("bp_rel_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("bp_rel_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_next_id", {31'b0, rsp_id}, 32'd0);
    checkOutput("bp_next_result", rsp_result, 32'd30);

    $display("[TB] illegal opcode");
    doReset();
    runOp(1'b0, 4'b1011, 32'd1, 32'd2, 32'd0, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("ill_count", {16'b0, txn_count}, 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, OP_SLTU, 32'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    req0_valid = 1'b1; req0_op = OP_OR;  req0_a = 32'h0F0; req0_b = 32'h00F;
    req1_valid = 1'b1; req1_op = OP_AND; req1_a = 32'h0F0; req1_b = 32'h0FF;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_ready0", {31'b0, req0_ready}, 32'd0);
    checkOutput("mid_rst_ready1", {31'b0, req1_ready}, 32'd0);
    @(negedge clk);
    checkOutput("mid_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("mid_busy_clr", {31'b0, busy}, 32'd0);
    checkOutput("mid_count", {16'b0, txn_count}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("mid_tie_ready0", {31'b0, req0_ready}, 32'd1);
    checkOutput("mid_tie_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_after_id", {31'b0, rsp_id}, 32'd0);
    checkOutput("mid_after_result", rsp_result, 32'h0000_00FF);

    $display("[TB] counter wrap and shifts");
    doReset();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0)
        runOp(1'b0, OP_SRA, 32'hFFFF_FFF8, 32'd2, 32'hFFFF_FFFE, 4'b0100, 1'b0);
      else
        runOp(1'b1, OP_SLL, 32'd1, 32'd2, 32'h0000_0004, 4'b0000, 1'b0);
    end
    @(negedge clk);
    checkOutput("wrap_count", {30'b0, w_txn_count}, 32'd1);
    checkOutput("wide_count", {16'b0, txn_count}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
